// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction-fetch sequencer: word type, fetch FSM
// states and the sequential-fetch address step.
package fetch_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Next sequential fetch address; wraps at the top of the address space
    // and never disturbs the two low (byte-offset) bits.
    function automatic word_t pc_increment(input word_t pc);
        return pc + word_t'(4);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-control bundle between the fetch sequencer, the icache, the hazard
// unit and the IF/ID latch. The fs side is the sequencer, tb drives it.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    // Inputs to the sequencer
    logic         ihit;
    logic         stall_hazard;
    logic         mem_busy;
    logic         redirect;
    word_t        redirect_pc;
    logic         halt;

    // Outputs from the sequencer
    word_t        imemaddr;
    logic         imemREN;
    word_t        pcp4;
    logic         ifid_en;
    logic         ifid_flush;
    word_t        fetch_count;
    word_t        bubble_count;
    fetch_state_t state;

    modport fs (
        input  ihit, stall_hazard, mem_busy, redirect, redirect_pc, halt,
        output imemaddr, imemREN, pcp4, ifid_en, ifid_flush,
               fetch_count, bubble_count, state
    );

    modport tb (
        output ihit, stall_hazard, mem_busy, redirect, redirect_pc, halt,
        input  imemaddr, imemREN, pcp4, ifid_en, ifid_flush,
               fetch_count, bubble_count, state
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the icache read request
// and generates the IF/ID load/flush controls. A redirect that lands during
// an icache miss is parked in redirect_q until the stale fill returns.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input logic            CLK,
    input logic            nRST,
    fetch_sequencer_if.fs  fif
);

    fetch_state_t state, next_state;
    word_t        pc, next_pc;
    word_t        redirect_q, next_redirect_q;
    word_t        fetch_count, bubble_count;
    logic         ifid_en, ifid_flush, imem_ren;

    // Next-state, next-PC and same-cycle IF/ID / icache controls.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        next_state      = state;
        next_pc         = pc;
        next_redirect_q = redirect_q;
        ifid_en         = 1'b0;
        ifid_flush      = 1'b0;
        imem_ren        = 1'b1;

        unique case (state)
            RUN: begin
                // A busy MEM stage freezes the pipe; redirect and halt come
                // from frozen stages and are still asserted afterwards.
                if (!fif.mem_busy) begin
                    if (fif.redirect) begin
                        ifid_flush = 1'b1;
                        if (fif.ihit) begin
                            next_pc = fif.redirect_pc;
                        end else begin
                            // Miss in flight on the old PC: wait it out.
                            next_redirect_q = fif.redirect_pc;
                            next_state      = SQUASH;
                        end
                    end else if (fif.halt) begin
                        ifid_flush = 1'b1;
                        next_state = HALTED;
                    end else if (fif.stall_hazard) begin
                        // Hold PC and IF/ID for the load-use bubble.
                        next_pc = pc;
                    end else if (fif.ihit) begin
                        ifid_en = 1'b1;
                        next_pc = pc_increment(pc);
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end
            end

            SQUASH: begin
                if (!fif.mem_busy) begin
                    // The returning instruction is wrong-path: always flush.
                    ifid_flush = 1'b1;
                    if (fif.ihit) begin
                        // A redirect arriving with the fill is the newest target.
                        next_pc    = fif.redirect ? fif.redirect_pc : redirect_q;
                        next_state = RUN;
                    end else if (fif.redirect) begin
                        next_redirect_q = fif.redirect_pc;
                    end
                end
            end

            HALTED: begin
                imem_ren   = 1'b0;
                ifid_flush = 1'b1;
            end

            default: begin
                next_state = RUN;
            end
        endcase
    end

    // PC, FSM state, parked redirect target and performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= RUN;
            pc           <= PC_INIT;
            redirect_q   <= '0;
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state        <= next_state;
            pc           <= next_pc;
            redirect_q   <= next_redirect_q;
            fetch_count  <= fetch_count + word_t'(ifid_en);
            bubble_count <= bubble_count + word_t'(ifid_flush);
        end
    end

    // In SQUASH the PC is held, so the fetch address is always the PC.
    assign fif.imemaddr     = pc;
    assign fif.imemREN      = imem_ren;
    assign fif.pcp4         = pc_increment(pc);
    assign fif.ifid_en      = ifid_en;
    assign fif.ifid_flush   = ifid_flush;
    assign fif.fetch_count  = fetch_count;
    assign fif.bubble_count = bubble_count;
    assign fif.state        = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural fetch model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;

    logic CLK = 1'b0;
    logic nRST;

    fetch_sequencer_if fif ();

    fetch_sequencer #(.PC_INIT(PC_INIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif.fs)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic  ih;
        logic  st;
        logic  mb;
        logic  rd;
        logic  hl;
        word_t rpc;
    } stim_t;

    typedef struct packed {
        word_t addr;
        logic  ren;
        word_t pcp4;
        logic  en;
        logic  flush;
        word_t fc;
        word_t bc;
    } obs_t;

    // Behavioural model: where fetch is, whether it is waiting out a stale
    // fill, whether the core has stopped, and the two event tallies.
    word_t m_pc, m_target, m_fetch, m_bubble;
    bit    m_squash, m_halted;

    obs_t         reset_obs;
    fetch_state_t reset_state;

    function automatic obs_t model_out();
        obs_t e;
        e.addr  = m_pc;
        e.ren   = !m_halted;
        e.pcp4  = m_pc + 32'd4;
        e.en    = !m_halted && !m_squash && !fif.mem_busy && !fif.redirect &&
                  !fif.halt && !fif.stall_hazard && fif.ihit;
        e.flush = m_halted || (!fif.mem_busy &&
                  (m_squash || fif.redirect || fif.halt ||
                   (!fif.stall_hazard && !fif.ihit)));
        e.fc    = m_fetch;
        e.bc    = m_bubble;
        return e;
    endfunction

    function automatic obs_t dut_out();
        obs_t o;
        o.addr  = fif.imemaddr;
        o.ren   = fif.imemREN;
        o.pcp4  = fif.pcp4;
        o.en    = fif.ifid_en;
        o.flush = fif.ifid_flush;
        o.fc    = fif.fetch_count;
        o.bc    = fif.bubble_count;
        return o;
    endfunction

    task automatic model_reset();
        m_pc = PC_INIT; m_target = '0; m_fetch = '0; m_bubble = '0;
        m_squash = 0; m_halted = 0;
    endtask

    // Apply inputs just after the falling edge and let them settle.
    task automatic drive(input stim_t s);
        @(negedge CLK);
        fif.ihit = s.ih; fif.stall_hazard = s.st; fif.mem_busy = s.mb;
        fif.redirect = s.rd; fif.halt = s.hl; fif.redirect_pc = s.rpc;
        #1;
    endtask

    // Step the model with the inputs currently applied, then clock the DUT.
    task automatic advance();
        obs_t e;
        e = model_out();
        m_fetch  += word_t'(e.en);
        m_bubble += word_t'(e.flush);
        if (!m_halted && !fif.mem_busy) begin
            if (m_squash) begin
                if (fif.redirect) m_target = fif.redirect_pc;
                if (fif.ihit) begin m_pc = m_target; m_squash = 0; end
            end else if (fif.redirect) begin
                if (fif.ihit) m_pc = fif.redirect_pc;
                else begin m_target = fif.redirect_pc; m_squash = 1; end
            end else if (fif.halt) begin
                m_halted = 1;
            end else if (!fif.stall_hazard && fif.ihit) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge CLK);
    endtask

    // Asynchronous reset pulse between clock edges; stall held so the edge
    // after release neither loads nor flushes IF/ID.
    task automatic do_reset();
        @(negedge CLK);
        fif.ihit = 0; fif.stall_hazard = 1; fif.mem_busy = 0;
        fif.redirect = 0; fif.halt = 0; fif.redirect_pc = '0;
        #1 nRST = 1'b0;
        #1;
        model_reset();
        reset_obs   = dut_out();
        reset_state = fif.state;
        nRST = 1'b1;
        advance();
    endtask

    function automatic stim_t mk(input logic ih, st, mb, rd, hl, input word_t rpc);
        stim_t s;
        s.ih = ih; s.st = st; s.mb = mb; s.rd = rd; s.hl = hl; s.rpc = rpc;
        return s;
    endfunction

    task automatic test_reset();
        obs_t e;
        do_reset();
        e = model_out();
        checks++;
        if (reset_obs !== e) begin
            errors++; $display("FAIL reset_outputs got %h want %h", reset_obs, e);
        end
        checks++;
        if (reset_obs.addr !== PC_INIT || reset_state !== RUN) begin
            errors++; $display("FAIL reset_pc_state got %h/%0d want %h/RUN",
                               reset_obs.addr, reset_state, PC_INIT);
        end
    endtask

    task automatic test_sequential();
        obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, 0, 0, 0, 0, '0));
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL seq_cycle%0d got %h want %h", i, o, e); end
            checks++;
            if (o.addr !== word_t'(4 * i) || o.en !== 1'b1) begin
                errors++; $display("FAIL seq_addr%0d got %h en=%b want %h en=1", i, o.addr, o.en, 4 * i);
            end
            advance();
        end
    endtask

    task automatic test_miss();
        obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            drive(mk(i == 3, 0, 0, 0, 0, '0));
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL miss_cycle%0d got %h want %h", i, o, e); end
            checks++;
            if (o.addr !== 32'h10 || o.fc !== 32'd4 || o.bc !== word_t'(i) || o.flush !== (i != 3)) begin
                errors++; $display("FAIL miss_hold%0d got pc=%h fc=%0d bc=%0d fl=%b", i, o.addr, o.fc, o.bc, o.flush);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive(mk(1, 1, 0, 0, 0, '0));
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_cycle%0d got %h want %h", i, o, e); end
            checks++;
            if (o.addr !== 32'h14 || o.en !== 1'b0 || o.flush !== 1'b0 || o.fc !== 32'd5 || o.bc !== 32'd3) begin
                errors++; $display("FAIL stall_hold%0d got pc=%h en=%b fl=%b fc=%0d bc=%0d",
                                   i, o.addr, o.en, o.flush, o.fc, o.bc);
            end
            advance();
        end
    endtask

    task automatic test_redirect_miss();
        obs_t e, o;
        stim_t seq [5];
        seq[0] = mk(0, 0, 0, 1, 0, 32'h40);
        seq[1] = mk(0, 0, 0, 0, 0, '0);
        seq[2] = mk(0, 0, 0, 0, 0, '0);
        seq[3] = mk(1, 0, 0, 0, 0, '0);
        seq[4] = mk(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL redir_miss_cycle%0d got %h want %h", i, o, e); end
            if (i == 2) begin
                checks++;
                if (fif.state !== SQUASH || o.addr !== 32'h14) begin
                    errors++; $display("FAIL redir_squash got state=%0d pc=%h want SQUASH pc=14", fif.state, o.addr);
                end
            end
            if (i == 4) begin
                checks++;
                if (fif.state !== RUN || o.addr !== 32'h40 || o.en !== 1'b1) begin
                    errors++; $display("FAIL redir_target got state=%0d pc=%h en=%b want RUN 40 en=1",
                                       fif.state, o.addr, o.en);
                end
            end
            advance();
        end
    endtask

    task automatic test_redirect_halt();
        obs_t e, o;
        drive(mk(1, 0, 0, 1, 1, 32'h80));
        checks++;
        if (fif.ifid_flush !== 1'b1) begin errors++; $display("FAIL redir_halt_flush got %b want 1", fif.ifid_flush); end
        advance();
        drive(mk(1, 0, 0, 0, 1, '0));
        checks++;
        if (fif.imemaddr !== 32'h80 || fif.state !== RUN) begin
            errors++; $display("FAIL redir_beats_halt got pc=%h state=%0d want 80 RUN", fif.imemaddr, fif.state);
        end
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(mk(1, 0, 0, 0, 0, '0));
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL halted_cycle%0d got %h want %h", i, o, e); end
            checks++;
            if (fif.state !== HALTED || o.ren !== 1'b0 || o.addr !== 32'h80 || o.flush !== 1'b1) begin
                errors++; $display("FAIL halted_hold%0d got state=%0d ren=%b pc=%h fl=%b",
                                   i, fif.state, o.ren, o.addr, o.flush);
            end
            advance();
        end
    endtask

    task automatic test_busy_redirect();
        obs_t e, o;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 2)      drive(mk(1, 0, 0, 0, 0, '0));
            else if (i < 5) drive(mk(1, 0, 1, 1, 0, 32'h100));
            else            drive(mk(1, 0, 0, 1, 0, 32'h100));
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL busy_cycle%0d got %h want %h", i, o, e); end
            if (i >= 2 && i < 5) begin
                checks++;
                if (o.addr !== 32'h8 || o.flush !== 1'b0 || o.en !== 1'b0) begin
                    errors++; $display("FAIL busy_freeze%0d got pc=%h fl=%b en=%b", i, o.addr, o.flush, o.en);
                end
            end
            advance();
        end
        drive(mk(1, 0, 0, 0, 0, '0));
        checks++;
        if (fif.imemaddr !== 32'h100) begin errors++; $display("FAIL busy_redirect_taken got %h want 100", fif.imemaddr); end
        advance();
    endtask

    task automatic test_wrap();
        drive(mk(1, 0, 0, 1, 0, 32'hFFFF_FFFC));
        advance();
        drive(mk(1, 0, 0, 0, 0, '0));
        checks++;
        if (fif.imemaddr !== 32'hFFFF_FFFC || fif.pcp4 !== 32'h0) begin
            errors++; $display("FAIL wrap_pcp4 got pc=%h pcp4=%h want FFFFFFFC 0", fif.imemaddr, fif.pcp4);
        end
        advance();
        drive(mk(0, 1, 0, 0, 0, '0));
        checks++;
        if (fif.imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", fif.imemaddr); end
        advance();
    endtask

    task automatic test_reset_mid_squash();
        drive(mk(0, 0, 0, 1, 0, 32'h200));
        advance();
        drive(mk(0, 0, 0, 0, 0, '0));
        advance();
        do_reset();
        checks++;
        if (reset_state !== RUN || reset_obs.addr !== PC_INIT || reset_obs.fc !== 0 || reset_obs.bc !== 0) begin
            errors++; $display("FAIL squash_reset got state=%0d pc=%h fc=%0d bc=%0d",
                               reset_state, reset_obs.addr, reset_obs.fc, reset_obs.bc);
        end
        drive(mk(1, 0, 0, 0, 0, '0));
        advance();
        drive(mk(1, 0, 0, 0, 0, '0));
        checks++;
        if (fif.imemaddr !== 32'h4) begin errors++; $display("FAIL squash_target_lost got %h want 4", fif.imemaddr); end
        advance();
    endtask

    task automatic test_random();
        obs_t e, o;
        stim_t s;
        int halted_cycles = 0;
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            s.ih  = ($urandom_range(99) < 65);
            s.st  = ($urandom_range(99) < 15);
            s.mb  = ($urandom_range(99) < 15);
            s.rd  = ($urandom_range(99) < 12);
            s.hl  = ($urandom_range(99) < 3);
            s.rpc = ($urandom_range(9) == 0) ? word_t'($urandom) : {$urandom_range(32'h3FFF_FFFF), 2'b00};
            drive(s);
            e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                errors++;
                if (bad < 10) $display("FAIL random_cycle%0d got %h want %h", i, o, e);
                bad++;
            end
            advance();
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            if (halted_cycles > 3 || $urandom_range(99) == 0) begin
                do_reset();
                halted_cycles = 0;
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        fif.ihit = 0; fif.stall_hazard = 1; fif.mem_busy = 0;
        fif.redirect = 0; fif.halt = 0; fif.redirect_pc = '0;
        model_reset();
        #12 nRST = 1'b1;
        test_reset();
        test_sequential();
        test_miss();
        test_stall();
        test_redirect_miss();
        test_redirect_halt();
        test_busy_redirect();
        test_wrap();
        test_reset_mid_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
